load_store_unit: RTL and testbench

Data-memory access stage between the execute/memory pipeline and the data RAM. It accepts one load or store request at a time and drives a word-addressed memory bus with byte enables, waiting through memory wait states. Load data is lane-selected and sign- or zero-extended to 32 bits before it returns to writeback. Misaligned addresses and memory timeouts are reported as exceptions.

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store stage driving a word-addressed data bus with byte enables.
// Latency: aligned access responds the cycle after mem_ack (or timeout); misaligned responds the cycle after accept.
// Backpressure: req_ready only in IDLE; mem_req is held with stable address/enables until mem_ack or timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic [31:0] resp_badvaddr
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Last counter value before the bus is declared dead (unused when TIMEOUT is 0).
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    op_q;
  logic [31:0]   addr_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;

  logic [1:0]    in_size;   // 0 byte, 1 halfword, 2 word
  logic          in_store;
  logic          in_misal;
  logic [3:0]    in_be;
  logic [31:0]   in_wdata;
  logic          st_q;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld_data;
  logic          to_hit;
  logic          accept;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_ready && req_valid;
  assign in_store  = req_op[2] & (req_op[1] | req_op[0]);
  assign st_q      = op_q[2] & (op_q[1] | op_q[0]);
  assign to_hit    = (TIMEOUT != 0) && (cnt == TO_LAST) && !mem_ack;

  // Access size of the incoming op.
  always_comb begin
    in_size = 2'd2;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: in_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: in_size = 2'd1;
      default:              in_size = 2'd2;
    endcase
  end

  // Alignment check, byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    in_misal = 1'b0;
    in_be    = 4'b1111;
    in_wdata = req_wdata;
    case (in_size)
      2'd0: begin
        in_be    = 4'b0001 << req_addr[1:0];
        in_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        in_misal = req_addr[0];
        in_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        in_misal = |req_addr[1:0];
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned word.
  always_comb begin
    lane_b  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    case (op_q)
      OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_data = {24'b0, lane_b};
      OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_data = {16'b0, lane_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: misaligned skips the bus; WAIT ends on ack or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = in_misal ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack || to_hit) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, bus drive, timeout count and one-cycle response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= 3'd0;
      addr_q        <= 32'd0;
      rd_q          <= 5'd0;
      cnt           <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_be        <= 4'd0;
      mem_wdata     <= 32'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_rd       <= 5'd0;
      resp_exc      <= 1'b0;
      resp_exccode  <= 5'd0;
      resp_badvaddr <= 32'd0;
    end else begin
      // Response fields live for exactly one cycle unless set below.
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_rd       <= 5'd0;
      resp_exc      <= 1'b0;
      resp_exccode  <= 5'd0;
      resp_badvaddr <= 32'd0;
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        rd_q   <= req_rd;
        if (in_misal) begin
          resp_valid    <= 1'b1;
          resp_rd       <= req_rd;
          resp_exc      <= 1'b1;
          resp_exccode  <= in_store ? EXC_ADES : EXC_ADEL;
          resp_badvaddr <= req_addr;
        end else begin
          cnt       <= '0;
          mem_req   <= 1'b1;
          mem_we    <= in_store;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_be    <= in_be;
          mem_wdata <= in_wdata;
        end
      end else if (state == S_WAIT) begin
        if (mem_ack) begin
          mem_req    <= 1'b0;
          resp_valid <= 1'b1;
          resp_rd    <= rd_q;
          resp_rdata <= st_q ? 32'd0 : ld_data;
        end else if (to_hit) begin
          mem_req       <= 1'b0;
          resp_valid    <= 1'b1;
          resp_rd       <= rd_q;
          resp_exc      <= 1'b1;
          resp_exccode  <= EXC_DBE;
          resp_badvaddr <= addr_q;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized load/store transactions against a behavioural model.
// Latency: checks every cycle of each transaction against the expected accept/response timeline.
// Backpressure: garbage requests are presented while busy and must be ignored.
module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_exc;
  logic [4:0]  resp_exccode;
  logic [31:0] resp_badvaddr;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_exc(resp_exc), .resp_exccode(resp_exccode), .resp_badvaddr(resp_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd5: return 1;
      3'd2, 3'd3, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic bit op_signed(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd2);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    int off = int'(addr % 4);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
    int sz = op_size(op);
    if (sz == 1) return (w % 256) * 32'h0101_0101;
    if (sz == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    int sz = op_size(op);
    logic [31:0] span;
    logic [31:0] v;
    if (sz == 4) return word;
    span = 32'd1 << (8 * sz);
    v = (word >> (8 * (addr % 4))) % span;
    if (op_signed(op) && v >= span / 2) v = v - span;
    return v;
  endfunction

  // One full transaction; ack_at = cycle offset of mem_ack after accept (0 = never).
  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input int ack_at, input logic [31:0] rword,
                     output logic [31:0] got_rdata, output logic [4:0] got_code);
    int          sz;
    bit          st;
    bit          mis;
    bit          dbe;
    int          resp_at;
    logic [4:0]  e_code;
    logic [31:0] e_rdata;
    logic [31:0] r;
    sz  = op_size(op);
    st  = (op >= 3'd5);
    mis = (addr % sz) != 0;
    dbe = 1'b0;
    if (mis) resp_at = 1;
    else if (ack_at >= 1 && (TO == 0 || ack_at <= TO)) resp_at = ack_at + 1;
    else begin resp_at = TO + 1; dbe = 1'b1; end
    e_code  = mis ? (st ? 5'd5 : 5'd4) : (dbe ? 5'd7 : 5'd0);
    e_rdata = (st || e_code != 0) ? 32'd0 : model_load(op, addr, rword);

    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    for (int c = 1; c < resp_at; c++) begin
      chk("mem_req_wait", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(st));
      chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("mem_be", 32'(mem_be), 32'(model_be(op, addr)));
      if (st) chk("mem_wdata", mem_wdata, model_wdata(op, wd));
      chk("ready_busy", 32'(req_ready), 32'd0);
      // busy: present a garbage request that must be ignored
      r = $urandom();
      req_valid = 1'b1; req_op = r[2:0]; req_addr = $urandom(); req_rd = r[7:3];
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? rword : $urandom();
      @(negedge clk);
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("mem_req_resp", 32'(mem_req), 32'd0);
    chk("ready_resp", 32'(req_ready), 32'd0);
    chk("resp_rd", 32'(resp_rd), 32'(rd));
    chk("resp_exc", 32'(resp_exc), 32'(e_code != 0));
    chk("resp_exccode", 32'(resp_exccode), 32'(e_code));
    chk("resp_badvaddr", resp_badvaddr, (e_code != 0) ? addr : 32'd0);
    chk("resp_rdata", resp_rdata, e_rdata);
    got_rdata = resp_rdata;
    got_code  = resp_exccode;
    @(negedge clk);
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("resp_clear", resp_rdata | resp_badvaddr | 32'(resp_exccode) | 32'(resp_exc), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] got;
  logic [4:0]  code;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    // reset state
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem", 32'(mem_req) | 32'(mem_we) | mem_addr | 32'(mem_be) | mem_wdata, 32'd0);
    chk("rst_resp", 32'(resp_valid) | resp_rdata | 32'(resp_rd) | 32'(resp_exc)
                    | 32'(resp_exccode) | resp_badvaddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // stray ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_ignored", 32'(resp_valid), 32'd0);

    // directed cases
    txn(3'd0, 32'h0000_1003, 32'd0, 5'd1, 1, 32'h8012_3456, got, code);
    chk("lb_sext", got, 32'hFFFF_FF80);
    txn(3'd3, 32'h0000_2002, 32'd0, 5'd2, 1, 32'hBEEF_1234, got, code);
    chk("lhu_zext", got, 32'h0000_BEEF);
    txn(3'd2, 32'h0000_2002, 32'd0, 5'd3, 1, 32'hBEEF_1234, got, code);
    chk("lh_sext", got, 32'hFFFF_BEEF);
    txn(3'd1, 32'h0000_2001, 32'd0, 5'd4, 2, 32'h0000_F200, got, code);
    chk("lbu_zext", got, 32'h0000_00F2);
    txn(3'd5, 32'h0000_0010, 32'h0000_00A5, 5'd5, 1, 32'd0, got, code);
    txn(3'd6, 32'h0000_0012, 32'h0000_1234, 5'd6, 1, 32'd0, got, code);
    txn(3'd7, 32'h0000_0020, 32'hDEAD_BEEF, 5'd7, 3, 32'd0, got, code);
    txn(3'd4, 32'h0000_1006, 32'd0, 5'd8, 1, 32'd0, got, code);
    chk("lw_misal_code", 32'(code), 32'd4);
    txn(3'd6, 32'h0000_0011, 32'd0, 5'd9, 1, 32'd0, got, code);
    chk("sh_misal_code", 32'(code), 32'd5);
    txn(3'd4, 32'h0000_0100, 32'd0, 5'd10, 5, 32'h0BAD_CAFE, got, code);
    chk("lw_wait5", got, 32'h0BAD_CAFE);
    txn(3'd4, 32'h0000_0104, 32'd0, 5'd11, 0, 32'd0, got, code);
    chk("timeout_code", 32'(code), 32'd7);
    txn(3'd4, 32'h0000_0108, 32'd0, 5'd12, TO, 32'h5555_AAAA, got, code);
    chk("ack_at_last_code", 32'(code), 32'd0);

    // reset during WAIT
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_0080; req_rd = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_ignored", 32'(resp_valid), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    txn(3'd4, 32'h0000_0040, 32'd0, 5'd14, 1, 32'hCAFE_F00D, got, code);
    chk("post_rst_lw", got, 32'hCAFE_F00D);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] w;
      int          r;
      int          ack;
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~32'(op_size(op) - 1);
      w  = $urandom();
      r  = int'($urandom_range(0, 9));
      ack = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : int'($urandom_range(1, 4));
      txn(op, a, w, 5'($urandom_range(0, 31)), ack, $urandom(), got, code);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
